// File: rtl/decode_scoreboard.sv
// decode_scoreboard
// Register-hazard scheduler for the decode stage. Each architectural register
// (except r0) has a small counter of in-flight writes. Decode is stalled while
// an issuing instruction reads a register with a pending write, or writes a
// register whose counter is saturated. Writebacks retire pending writes.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : a source read of a register with exactly one pending write is
//               allowed in the same cycle as that register's writeback (the
//               register file forwards the write data).
//   undefined : any pending write on a source register stalls, regardless of a
//               concurrent writeback.
module decode_scoreboard #(
   parameter int NREG  = 32,
   parameter int CNT_W = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            issue_valid,
   input  logic [4:0]      issue_rs,
   input  logic [4:0]      issue_rt,
   input  logic            issue_uses_rs,
   input  logic            issue_uses_rt,
   input  logic            issue_writes,
   input  logic [4:0]      issue_dst,
   input  logic            wb_valid,
   input  logic [4:0]      wb_reg,
   input  logic            flush,
   output logic            issue_stall,
   output logic [NREG-1:0] busy_mask,
   output logic            underflow_err
);

   localparam int IDX_W = 5;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // Entry 0 exists only so register indices map directly; it is held at zero.
   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic [NREG-1:0]  busy_q;
   logic [NREG-1:0]  busy_d;
   logic             underflow_q;
   logic             underflow_d;

   logic rs_byp_s;
   logic rt_byp_s;
   logic rs_haz_s;
   logic rt_haz_s;
   logic dst_haz_s;
   logic stall_s;
   logic accept_wr_s;
   logic wb_do_s;
   logic wb_underflow_s;

`ifdef WB_BYPASS_EN
   // A source whose only pending write is retiring this cycle is forwarded.
   always_comb begin
      rs_byp_s = wb_valid && (wb_reg == issue_rs) && (cnt_q[issue_rs] == CNT_ONE);
      rt_byp_s = wb_valid && (wb_reg == issue_rt) && (cnt_q[issue_rt] == CNT_ONE);
   end
`else
   // No forwarding: a pending write always blocks its readers.
   always_comb begin
      rs_byp_s = 1'b0;
      rt_byp_s = 1'b0;
   end
`endif

   // Hazard detection and stall, purely from current counters and issue inputs.
   always_comb begin
      rs_haz_s  = issue_uses_rs && (issue_rs != 5'd0) &&
                  (cnt_q[issue_rs] != CNT_ZERO) && !rs_byp_s;
      rt_haz_s  = issue_uses_rt && (issue_rt != 5'd0) &&
                  (cnt_q[issue_rt] != CNT_ZERO) && !rt_byp_s;
      dst_haz_s = issue_writes && (issue_dst != 5'd0) &&
                  (cnt_q[issue_dst] == CNT_MAX);
      stall_s     = issue_valid && (rs_haz_s || rt_haz_s || dst_haz_s);
      accept_wr_s = issue_valid && !stall_s && issue_writes && (issue_dst != 5'd0);
      wb_do_s     = wb_valid && (wb_reg != 5'd0);
   end

   // Next counter values: flush wins, then net-zero, increment, decrement.
   always_comb begin
      wb_underflow_s = 1'b0;
      cnt_d[0]       = CNT_ZERO;
      busy_d         = {NREG{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         if (flush) begin
            cnt_d[i] = CNT_ZERO;
         end else if (accept_wr_s && (issue_dst == IDX_W'(i)) &&
                      wb_do_s && (wb_reg == IDX_W'(i))) begin
            cnt_d[i] = cnt_q[i];
         end else if (accept_wr_s && (issue_dst == IDX_W'(i))) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else if (wb_do_s && (wb_reg == IDX_W'(i))) begin
            if (cnt_q[i] == CNT_ZERO) begin
               cnt_d[i]       = CNT_ZERO;
               wb_underflow_s = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
         end else begin
            cnt_d[i] = cnt_q[i];
         end
      end
      for (int i = 1; i < NREG; i++) begin
         busy_d[i] = (cnt_d[i] != CNT_ZERO);
      end
      underflow_d = underflow_q | wb_underflow_s;
   end

   // State registers; busy_mask is registered from the same next-state counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= CNT_ZERO;
         end
         busy_q      <= {NREG{1'b0}};
         underflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         busy_q      <= busy_d;
         underflow_q <= underflow_d;
      end
   end

   assign issue_stall   = stall_s;
   assign busy_mask     = busy_q;
   assign underflow_err = underflow_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed testbench for decode_scoreboard with hand-computed expectations.
// Build with +define+WB_BYPASS_EN to check the bypass variant.
module tb_decode_scoreboard;

   logic        clk;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_rs;
   logic [4:0]  issue_rt;
   logic        issue_uses_rs;
   logic        issue_uses_rt;
   logic        issue_writes;
   logic [4:0]  issue_dst;
   logic        wb_valid;
   logic [4:0]  wb_reg;
   logic        flush;
   logic        issue_stall;
   logic [31:0] busy_mask;
   logic        underflow_err;

   int total;
   int bad;

   decode_scoreboard #(.NREG(32), .CNT_W(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .issue_valid   (issue_valid),
      .issue_rs      (issue_rs),
      .issue_rt      (issue_rt),
      .issue_uses_rs (issue_uses_rs),
      .issue_uses_rt (issue_uses_rt),
      .issue_writes  (issue_writes),
      .issue_dst     (issue_dst),
      .wb_valid      (wb_valid),
      .wb_reg        (wb_reg),
      .flush         (flush),
      .issue_stall   (issue_stall),
      .busy_mask     (busy_mask),
      .underflow_err (underflow_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_rs = 5'd0; issue_rt = 5'd0;
      issue_uses_rs = 1'b0; issue_uses_rt = 1'b0;
      issue_writes = 1'b0; issue_dst = 5'd0;
      wb_valid = 1'b0; wb_reg = 5'd0; flush = 1'b0;
   endtask

   // Advance one clock; inputs are changed 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_write(input logic [4:0] dst);
      idle();
      issue_valid = 1'b1; issue_writes = 1'b1; issue_dst = dst;
   endtask

   task automatic issue_read_rs(input logic [4:0] rs);
      idle();
      issue_valid = 1'b1; issue_uses_rs = 1'b1; issue_rs = rs;
   endtask

   task automatic wb_only(input logic [4:0] r);
      idle();
      wb_valid = 1'b1; wb_reg = r;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle();
      reset = 1'b1;
      #1;
      check("rst_busy", busy_mask, 32'h0000_0000);
      check("rst_stall", {31'd0, issue_stall}, 32'd0);
      check("rst_uf", {31'd0, underflow_err}, 32'd0);
      step();
      reset = 1'b0;
      step();

      // RAW on r8
      issue_write(5'd8);
      #1 check("raw_prod_stall", {31'd0, issue_stall}, 32'd0);
      step();
      check("raw_busy8", busy_mask, 32'h0000_0100);
      issue_read_rs(5'd8);
      #1 check("raw_dep_stall", {31'd0, issue_stall}, 32'd1);
      issue_valid = 1'b0;
      #1 check("raw_novalid_stall", {31'd0, issue_stall}, 32'd0);
      issue_valid = 1'b1;
      step();
      wb_valid = 1'b1; wb_reg = 5'd8;
      #1;
`ifdef WB_BYPASS_EN
      check("raw_wbcycle_stall", {31'd0, issue_stall}, 32'd0);
`else
      check("raw_wbcycle_stall", {31'd0, issue_stall}, 32'd1);
`endif
      step();
      issue_read_rs(5'd8);
      #1 check("raw_after_wb_stall", {31'd0, issue_stall}, 32'd0);
      check("raw_busy_clear", busy_mask, 32'h0000_0000);

      // Saturation on r3
      for (int k = 0; k < 3; k++) begin
         issue_write(5'd3);
         #1 check("sat_fill_stall", {31'd0, issue_stall}, 32'd0);
         step();
      end
      check("sat_busy3", busy_mask, 32'h0000_0008);
      issue_write(5'd3);
      #1 check("sat_full_stall", {31'd0, issue_stall}, 32'd1);
      wb_valid = 1'b1; wb_reg = 5'd3;
      #1 check("sat_dst_nobypass", {31'd0, issue_stall}, 32'd1);
      step();
      issue_write(5'd3);
      #1 check("sat_after_wb_stall", {31'd0, issue_stall}, 32'd0);
      step();
      #1 check("sat_back_to_max", {31'd0, issue_stall}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         wb_only(5'd3);
         step();
      end
      idle();
      #1 check("sat_drained", busy_mask, 32'h0000_0000);
      check("sat_no_uf", {31'd0, underflow_err}, 32'd0);

      // Register 0 with every other register busy
      for (int r = 1; r < 32; r++) begin
         issue_write(5'(r));
         step();
      end
      check("r0_all_busy", busy_mask, 32'hFFFF_FFFE);
      idle();
      issue_valid = 1'b1; issue_writes = 1'b1; issue_dst = 5'd0;
      issue_uses_rs = 1'b1; issue_rs = 5'd0; issue_uses_rt = 1'b1; issue_rt = 5'd0;
      #1 check("r0_stall", {31'd0, issue_stall}, 32'd0);
      step();
      wb_only(5'd0);
      step();
      check("r0_bit0", busy_mask, 32'hFFFF_FFFE);
      check("r0_wb_no_uf", {31'd0, underflow_err}, 32'd0);
      idle();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_clear", busy_mask, 32'h0000_0000);

      // Simultaneous accept and writeback on r4 (count 1) and r6 (count 0)
      issue_write(5'd4);
      step();
      issue_write(5'd4);
      wb_valid = 1'b1; wb_reg = 5'd4;
      #1 check("sim_stall", {31'd0, issue_stall}, 32'd0);
      step();
      check("sim_busy4", busy_mask, 32'h0000_0010);
      wb_only(5'd4);
      step();
      check("sim_cnt_was1", busy_mask, 32'h0000_0000);
      check("sim_no_uf", {31'd0, underflow_err}, 32'd0);
      issue_write(5'd6);
      wb_valid = 1'b1; wb_reg = 5'd6;
      step();
      idle();
      check("sim0_busy6", busy_mask, 32'h0000_0000);
      check("sim0_no_uf", {31'd0, underflow_err}, 32'd0);

      // Underflow after flush, sticky through flushes
      issue_write(5'd9);
      step();
      check("uf_busy9", busy_mask, 32'h0000_0200);
      idle();
      flush = 1'b1;
      step();
      check("uf_flushed", busy_mask, 32'h0000_0000);
      wb_only(5'd9);
      step();
      idle();
      check("uf_set", {31'd0, underflow_err}, 32'd1);
      check("uf_busy_zero", busy_mask, 32'h0000_0000);
      flush = 1'b1;
      step();
      step();
      flush = 1'b0;
      check("uf_sticky", {31'd0, underflow_err}, 32'd1);

      // Asynchronous reset mid-stall with cnt[5]=2
      issue_write(5'd5);
      step();
      step();
      check("rst2_busy5", busy_mask, 32'h0000_0020);
      issue_read_rs(5'd5);
      #1 check("rst2_stall_before", {31'd0, issue_stall}, 32'd1);
      #1 reset = 1'b1;
      #1;
      check("rst2_busy", busy_mask, 32'h0000_0000);
      check("rst2_stall", {31'd0, issue_stall}, 32'd0);
      check("rst2_uf", {31'd0, underflow_err}, 32'd0);
      step();
      reset = 1'b0;
      idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Register-hazard scheduler for the instruction decode stage. Tracks in-flight writes to each architectural register with a small per-register counter, stalls decode while an issuing instruction reads or writes a register with a pending write, and retires entries on writeback. Sits between decode (issue side) and the register-file write port (writeback side); its stall output gates instruction fetch and decode.

## Interface
- NREG, 32, number of architectural registers (register 0 is hard-wired zero, never tracked)
- CNT_W, 2, width of each per-register pending counter (max in-flight writes per register = 2^CNT_W-1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs  in  5  source register 1 (instr[25:21])
- issue_rt  in  5  source register 2 (instr[20:16])
- issue_uses_rs  in  1  instruction reads rs
- issue_uses_rt  in  1  instruction reads rt
- issue_writes  in  1  instruction writes a destination register
- issue_dst  in  5  destination register (rt or rd after RegDst selection)
- wb_valid  in  1  register-file write occurring this cycle (regWrite)
- wb_reg  in  5  register being written (writeRegister)
- flush  in  1  synchronous pipeline flush; clears all counters
- issue_stall  out  1  combinational; decode must hold the instruction
- busy_mask  out  NREG  registered; bit i = counter[i] != 0
- underflow_err  out  1  registered sticky; writeback to a register with zero pending

## Operation
- State: NREG-1 counters of CNT_W bits (index 1..NREG-1), busy_mask, underflow_err.
- Source hazard: rs_haz = issue_uses_rs && rs!=0 && cnt[rs]!=0; same for rt.
- Output hazard: dst_haz = issue_writes && dst!=0 && cnt[dst] == max (counter saturated).
- issue_stall = issue_valid && (rs_haz || rt_haz || dst_haz). issue_stall = 0 when issue_valid = 0.
- Accept = issue_valid && !issue_stall. On accept with issue_writes && dst!=0: cnt[dst] += 1 at next edge.
- Writeback: wb_valid && wb_reg!=0: cnt[wb_reg] -= 1 at next edge. If cnt[wb_reg]==0, counter stays 0 and underflow_err sets to 1.
- Same-cycle accept and writeback to same register: counter unchanged (net 0); no underflow even if count was 0.
- Writes to register 0 (issue or writeback) ignored entirely.
- flush: all counters to 0 at next edge; issue and writeback that cycle are discarded. underflow_err unaffected by flush.
- underflow_err cleared only by reset.

## Timing
- Reset (async, any time including mid-stall): all counters 0, busy_mask 0, underflow_err 0; issue_stall follows combinationally (0 unless a counter is nonzero, so 0).
- issue_stall: zero-cycle combinational from issue_* and current counters.
- Counter/busy_mask update: one cycle after accept or writeback edge.
- Dependent instruction issued the cycle after its producer stalls until the cycle after the producer's wb_valid (without bypass, see Configuration).
- busy_mask bit i reflects counters after the edge, consistent with counter state used for the stall compare in the same cycle.

## Configuration
- WB_BYPASS_EN defined: source hazard suppressed when cnt[src]==1 and wb_valid && wb_reg==src in the same cycle (register file forwards write data); dependent instruction accepted in the writeback cycle. dst_haz not bypassed.
- WB_BYPASS_EN undefined: source hazard whenever cnt[src]!=0, regardless of concurrent writeback; one extra stall cycle per RAW dependency.

## Test plan
- Reset: assert reset mid-stream with cnt[5]=2 -> busy_mask=0, issue_stall=0, underflow_err=0 immediately, without waiting for clk.
- RAW: accept write to r8; next cycle issue reading rs=8 -> issue_stall=1; wb_valid wb_reg=8 -> without bypass stall drops cycle after, with WB_BYPASS_EN stall drops in the wb cycle.
- Saturation: CNT_W=2, accept three writes to r3 (cnt=3); fourth issue writing r3 -> issue_stall=1; one wb to r3 -> accepted next cycle, cnt returns to 3.
- Register 0: issue writing r0 and reading rs=0 with all busy -> no stall, busy_mask bit0 stays 0.
- Simultaneous: cnt[4]=1, accept write r4 and wb r4 same cycle -> cnt[4]=1, busy_mask[4]=1 after edge.
- Underflow/flush: flush with cnt[9]=1, then wb r9 -> counters 0, underflow_err=1, stays 1 through further flushes until reset.
